// File: rtl/cpu_registers.sv
// RV32 integer register file: 32 x 32-bit, two registered read ports, one write port, x0 reads zero.
// Define REGISTERS_BYPASS_EN to forward same-edge write data to a matching read port.
module cpu_registers #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  I_clk,
  input  logic                  I_reset_n,
  input  logic [DATA_WIDTH-1:0] I_data,
  input  logic [ADDR_WIDTH-1:0] I_rs1,
  input  logic [ADDR_WIDTH-1:0] I_rs2,
  input  logic [ADDR_WIDTH-1:0] I_rd,
  input  logic                  I_re,
  input  logic                  I_we,
  output logic [DATA_WIDTH-1:0] O_regval1,
  output logic [DATA_WIDTH-1:0] O_regval2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic                  wr_en;

  // Entry 0 is never written, so x0 stays zero even though it has storage.
  assign wr_en = I_we && (I_rd != '0);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (I_rs1 != '0) begin
      rdata1 = regs[I_rs1];
`ifdef REGISTERS_BYPASS_EN
      if (wr_en && (I_rd == I_rs1)) rdata1 = I_data;
`endif
    end
    if (I_rs2 != '0) begin
      rdata2 = regs[I_rs2];
`ifdef REGISTERS_BYPASS_EN
      if (wr_en && (I_rd == I_rs2)) rdata2 = I_data;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values; this is what makes a same-edge read return the old data.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      // NOTE: the architectural contents must read zero after reset, so the array is cleared explicitly; this prevents mapping it onto block RAM.
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      O_regval1 <= '0;
      O_regval2 <= '0;
    end else begin
      if (wr_en) begin
        regs[I_rd] <= I_data;
      end
      if (I_re) begin
        O_regval1 <= rdata1;
        O_regval2 <= rdata2;
      end
    end
  end

endmodule

// File: tb/tb_cpu_registers.sv
// Scoreboard bench for cpu_registers: the driver queues hand-computed expected outputs per edge,
// and a monitor pops and compares them just after each rising edge.
module tb_cpu_registers;

  logic        clk;
  logic        reset_n;
  logic [31:0] data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        re;
  logic        we;
  logic [31:0] regval1;
  logic [31:0] regval2;

  typedef struct {
    string       name;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

`ifdef REGISTERS_BYPASS_EN
  localparam logic [31:0] SAME_EDGE_EXP = 32'h0000_1234;
`else
  localparam logic [31:0] SAME_EDGE_EXP = 32'h0000_0000;
`endif

  cpu_registers dut (
    .I_clk     (clk),
    .I_reset_n (reset_n),
    .I_data    (data),
    .I_rs1     (rs1),
    .I_rs2     (rs2),
    .I_rd      (rd),
    .I_re      (re),
    .I_we      (we),
    .O_regval1 (regval1),
    .O_regval2 (regval2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Drive one edge's inputs and queue the outputs expected right after that edge.
  task automatic drive(input bit rst_v, input bit we_v, input logic [4:0] rd_v,
                       input logic [31:0] d_v, input bit re_v, input logic [4:0] rs1_v,
                       input logic [4:0] rs2_v, input logic [31:0] e1, input logic [31:0] e2,
                       input string name);
    exp_t e;
    @(negedge clk);
    reset_n = rst_v;
    we      = we_v;
    rd      = rd_v;
    data    = d_v;
    re      = re_v;
    rs1     = rs1_v;
    rs2     = rs2_v;
    e.name  = name;
    e.exp1  = e1;
    e.exp2  = e2;
    sb.push_back(e);
  endtask

  // Monitor: compare once per edge while the scoreboard holds pending expectations.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".regval1"}, regval1, e.exp1);
        check({e.name, ".regval2"}, regval2, e.exp2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    rd      = '0;
    rs1     = '0;
    rs2     = '0;
    data    = '0;

    //    rst we rd  data           re rs1 rs2 exp1           exp2
    drive(0, 0, 0,  32'h0,         0, 0,  0,  32'h0,         32'h0,         "reset_init");
    drive(1, 1, 0,  32'h0000_FEFE, 0, 0,  0,  32'h0,         32'h0,         "x0_write_hold");
    drive(1, 0, 0,  32'h0,         1, 0,  0,  32'h0,         32'h0,         "x0_read");
    drive(1, 1, 1,  32'h0000_BEEF, 0, 0,  0,  32'h0,         32'h0,         "x1_write");
    drive(1, 0, 0,  32'h0,         1, 0,  1,  32'h0,         32'h0000_BEEF, "wr_readback");
    drive(1, 1, 1,  32'h0000_FEFE, 0, 0,  1,  32'h0,         32'h0000_BEEF, "hold");
    drive(1, 0, 0,  32'h0,         1, 0,  1,  32'h0,         32'h0000_FEFE, "hold_then_read");
    drive(1, 1, 5,  32'h0000_1234, 1, 5,  1,  SAME_EDGE_EXP, 32'h0000_FEFE, "same_edge_rw");
    drive(1, 0, 0,  32'h0,         1, 5,  5,  32'h0000_1234, 32'h0000_1234, "rw_next_edge");
    drive(1, 1, 3,  32'hA5A5_A5A5, 0, 0,  0,  32'h0000_1234, 32'h0000_1234, "x3_write_hold");
    drive(1, 1, 31, 32'hFFFF_FFFF, 0, 0,  0,  32'h0000_1234, 32'h0000_1234, "x31_write_hold");
    drive(1, 0, 0,  32'h0,         1, 3,  31, 32'hA5A5_A5A5, 32'hFFFF_FFFF, "dual_port");
    drive(1, 0, 0,  32'h0,         1, 31, 31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "same_index");
    drive(1, 1, 0,  32'h0000_DEAD, 1, 0,  3,  32'h0,         32'hA5A5_A5A5, "x0_same_edge");
    drive(0, 1, 2,  32'h0000_0777, 1, 3,  31, 32'h0,         32'h0,         "reset");
    drive(1, 0, 0,  32'h0,         1, 1,  31, 32'h0,         32'h0,         "reset_cleared");
    drive(1, 0, 0,  32'h0,         1, 2,  5,  32'h0,         32'h0,         "reset_priority");
    drive(1, 1, 7,  32'h0000_0042, 0, 0,  0,  32'h0,         32'h0,         "post_reset_write");
    drive(1, 0, 0,  32'h0,         1, 7,  3,  32'h0000_0042, 32'h0,         "post_reset_read");

    @(negedge clk);
    re = 1'b0;
    we = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
